// File: rtl/frame_buffer_manager_pkg.sv
// Shared types and constants for the double-buffered frame store.
// The rasterizer, display controller and SRAM all work in 20-bit word addresses.
package fb_pkg;

  localparam int unsigned FB_WIDTH  = 640;
  localparam int unsigned FB_HEIGHT = 480;
  localparam int unsigned FB_WORDS  = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned ADDR_W    = 20;

  typedef logic [15:0]       pixel_t;
  typedef logic [ADDR_W-1:0] addr_t;

  typedef enum logic [1:0] {
    CLEAR,
    DRAW,
    WAIT_SWAP
  } fb_state_t;

  localparam addr_t  DEF_BUF0_ADDR    = 20'h00000;
  localparam addr_t  DEF_BUF1_ADDR    = 20'h4B000;
  localparam pixel_t DEF_CLEAR_COLOR  = 16'h0000;

endpackage

// File: rtl/frame_buffer_manager_if.sv
// Rasterizer pixel-write channel: valid/ready handshake with an offset address.
// master = rasterizer, slave = frame buffer manager.
interface frame_buffer_manager_if;
  import fb_pkg::*;

  logic   wr_valid;
  logic   wr_ready;
  addr_t  wr_addr;
  pixel_t wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/frame_buffer_manager_clear_engine.sv
// Word counter for clearing the back buffer; advances only on cycles a clear write is issued.
// done flags the cycle carrying the final write of the buffer.
module fb_clear_engine
  import fb_pkg::*;
#(
  parameter int unsigned FB_WORDS = fb_pkg::FB_WORDS
) (
  input  logic  clock,
  input  logic  reset,
  input  logic  en,
  input  logic  restart,
  output addr_t cnt,
  output logic  done
);

  assign done = en && (cnt == addr_t'(FB_WORDS - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= done ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/frame_buffer_manager.sv
// Double-buffer owner and single-port SRAM arbiter: display reads win, then clear or rasterizer writes.
// Buffers swap on the first frame boundary after the rasterizer reports a finished frame.
module frame_buffer_manager
  import fb_pkg::*;
#(
  parameter addr_t       BUF0_ADDR   = DEF_BUF0_ADDR,
  parameter addr_t       BUF1_ADDR   = DEF_BUF1_ADDR,
  parameter int unsigned FB_WORDS    = fb_pkg::FB_WORDS,
  parameter pixel_t      CLEAR_COLOR = DEF_CLEAR_COLOR
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         completed_frame,
  input  logic                         disp_read_enable,
  input  addr_t                        disp_read_addr,
  output addr_t                        front_buffer_addr,
  output logic                         raster_ready,
  input  logic                         frame_done,
  frame_buffer_manager_if.slave        wr,
  output addr_t                        sram_addr,
  output logic                         sram_we,
  output logic                         sram_oe,
  output pixel_t                       sram_wdata
);

  fb_state_t state;
  addr_t     back_buffer_addr;
  addr_t     clear_cnt;
  logic      clear_en;
  logic      clear_done;

  fb_clear_engine #(
    .FB_WORDS (FB_WORDS)
  ) u_clear (
    .clock   (clock),
    .reset   (reset),
    .en      (clear_en),
    .restart (state != CLEAR),
    .cnt     (clear_cnt),
    .done    (clear_done)
  );

  // Port outputs are combinational; reset is folded in so they read idle while it is held.
  always_comb begin
    sram_addr   = '0;
    sram_we     = 1'b0;
    sram_oe     = 1'b0;
    sram_wdata  = '0;
    wr.wr_ready = 1'b0;
    clear_en    = 1'b0;
    if (!reset) begin
      sram_addr = '0;
    end else if (disp_read_enable) begin
      sram_addr = disp_read_addr;
      sram_oe   = 1'b1;
    end else begin
      case (state)
        CLEAR: begin
          clear_en   = 1'b1;
          sram_we    = 1'b1;
          sram_addr  = back_buffer_addr + clear_cnt;
          sram_wdata = CLEAR_COLOR;
        end
        DRAW: begin
          wr.wr_ready = 1'b1;
          sram_we     = wr.wr_valid;
          sram_addr   = back_buffer_addr + wr.wr_addr;
          sram_wdata  = wr.wr_data;
        end
        default: begin
          sram_we = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= CLEAR;
      front_buffer_addr <= BUF0_ADDR;
      back_buffer_addr  <= BUF1_ADDR;
      raster_ready      <= 1'b0;
    end else begin
      case (state)
        CLEAR: begin
          if (clear_done) begin
            state        <= DRAW;
            raster_ready <= 1'b1;
          end
        end
        DRAW: begin
          if (frame_done) begin
            state        <= WAIT_SWAP;
            raster_ready <= 1'b0;
          end
        end
        WAIT_SWAP: begin
          if (completed_frame) begin
            front_buffer_addr <= back_buffer_addr;
            back_buffer_addr  <= front_buffer_addr;
            state             <= CLEAR;
          end
        end
        default: begin
          state        <= CLEAR;
          raster_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_frame_buffer_manager.sv
// Directed-plus-random bench for frame_buffer_manager with a small 16-word buffer.
// Expected SRAM traffic comes from a model that tracks only which buffer is front/back and the phase.
module tb_frame_buffer_manager;

  localparam int unsigned WORDS = 16;

  logic        clock = 1'b0;
  logic        reset;
  logic        completed_frame;
  logic        disp_read_enable;
  logic [19:0] disp_read_addr;
  logic [19:0] front_buffer_addr;
  logic        raster_ready;
  logic        frame_done;
  logic [19:0] sram_addr;
  logic        sram_we;
  logic        sram_oe;
  logic [15:0] sram_wdata;

  frame_buffer_manager_if wr_bus ();

  frame_buffer_manager #(
    .FB_WORDS (WORDS)
  ) dut (
    .clock             (clock),
    .reset             (reset),
    .completed_frame   (completed_frame),
    .disp_read_enable  (disp_read_enable),
    .disp_read_addr    (disp_read_addr),
    .front_buffer_addr (front_buffer_addr),
    .raster_ready      (raster_ready),
    .frame_done        (frame_done),
    .wr                (wr_bus),
    .sram_addr         (sram_addr),
    .sram_we           (sram_we),
    .sram_oe           (sram_oe),
    .sram_wdata        (sram_wdata)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  logic [19:0] exp_front;
  logic [19:0] exp_back;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic swap_model();
    logic [19:0] t;
    t         = exp_front;
    exp_front = exp_back;
    exp_back  = t;
  endtask

  // One clear write expected this cycle at word n of the back buffer.
  task automatic chk_clear_word(input int n);
    chk("clr_we",    32'(sram_we), 32'd1);
    chk("clr_oe",    32'(sram_oe), 32'd0);
    chk("clr_addr",  32'(sram_addr), 32'(20'(exp_back + 20'(n))));
    chk("clr_data",  32'(sram_wdata), 32'h0);
    chk("clr_rdy",   32'(raster_ready), 32'd0);
    chk("clr_wrrdy", 32'(wr_bus.wr_ready), 32'd0);
  endtask

  task automatic clear_no_reads();
    for (int n = 0; n < int'(WORDS); n++) begin
      #1;
      chk_clear_word(n);
      step();
    end
    #1;
    chk("rdy_after_clear", 32'(raster_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic        dre;
    logic        wv;
    logic [19:0] wa;
    logic [15:0] wd;
    logic [19:0] ra;
    logic [19:0] ea;
    int          n;
    int          cyc;

    exp_front        = 20'h00000;
    exp_back         = 20'h4B000;
    reset            = 1'b0;
    completed_frame  = 1'b0;
    frame_done       = 1'b0;
    disp_read_enable = 1'b0;
    disp_read_addr   = '0;
    wr_bus.wr_valid  = 1'b1;
    wr_bus.wr_addr   = 20'h3;
    wr_bus.wr_data   = 16'hABCD;

    #2;
    chk("rst_front", 32'(front_buffer_addr), 32'h00000);
    chk("rst_rdy",   32'(raster_ready), 32'd0);
    chk("rst_wrrdy", 32'(wr_bus.wr_ready), 32'd0);
    chk("rst_we",    32'(sram_we), 32'd0);
    chk("rst_oe",    32'(sram_oe), 32'd0);
    chk("rst_addr",  32'(sram_addr), 32'h0);
    chk("rst_wdata", 32'(sram_wdata), 32'h0);
    step();
    step();

    // Release reset; first clear with stray frame_done / completed_frame pulses that must be ignored.
    reset = 1'b1;
    for (int i = 0; i < int'(WORDS); i++) begin
      frame_done      = 1'($urandom);
      completed_frame = 1'($urandom);
      #1;
      chk_clear_word(i);
      chk("clr_front", 32'(front_buffer_addr), 32'(exp_front));
      step();
    end
    frame_done      = 1'b0;
    completed_frame = 1'b0;
    #1;
    chk("rdy_first", 32'(raster_ready), 32'd1);

    // Directed draw write, then the same write pre-empted by a display read.
    wr_bus.wr_valid = 1'b1;
    wr_bus.wr_addr  = 20'h5;
    wr_bus.wr_data  = 16'hF800;
    #1;
    chk("draw_wrrdy", 32'(wr_bus.wr_ready), 32'd1);
    chk("draw_addr",  32'(sram_addr), 32'h4B005);
    chk("draw_we",    32'(sram_we), 32'd1);
    chk("draw_data",  32'(sram_wdata), 32'hF800);
    disp_read_enable = 1'b1;
    disp_read_addr   = 20'h00010;
    #1;
    chk("rd_addr",  32'(sram_addr), 32'h00010);
    chk("rd_oe",    32'(sram_oe), 32'd1);
    chk("rd_we",    32'(sram_we), 32'd0);
    chk("rd_wrrdy", 32'(wr_bus.wr_ready), 32'd0);
    step();

    // Random draw traffic, including wrap-around offsets and ignored completed_frame.
    for (int i = 0; i < 30; i++) begin
      dre = 1'($urandom);
      wv  = 1'($urandom);
      wa  = (i % 5 == 0) ? 20'(20'hFFFFF - 20'($urandom_range(0, 15))) : 20'($urandom);
      wd  = 16'($urandom);
      ra  = 20'($urandom);
      disp_read_enable = dre;
      disp_read_addr   = ra;
      wr_bus.wr_valid  = wv;
      wr_bus.wr_addr   = wa;
      wr_bus.wr_data   = wd;
      completed_frame  = 1'($urandom);
      ea = dre ? ra : 20'(exp_back + wa);
      #1;
      chk("rnd_addr",  32'(sram_addr), 32'(ea));
      chk("rnd_we",    32'(sram_we), 32'(!dre && wv));
      chk("rnd_oe",    32'(sram_oe), 32'(dre));
      chk("rnd_wrrdy", 32'(wr_bus.wr_ready), 32'(!dre));
      if (!dre && wv) chk("rnd_data", 32'(sram_wdata), 32'(wd));
      chk("rnd_rdy",   32'(raster_ready), 32'd1);
      chk("rnd_front", 32'(front_buffer_addr), 32'(exp_front));
      step();
    end
    completed_frame = 1'b0;

    // frame_done with a write in the same cycle; coincident completed_frame is ignored.
    disp_read_enable = 1'b0;
    wr_bus.wr_valid  = 1'b1;
    wr_bus.wr_addr   = 20'h9;
    wr_bus.wr_data   = 16'h07E0;
    frame_done       = 1'b1;
    completed_frame  = 1'b1;
    #1;
    chk("fd_we",   32'(sram_we), 32'd1);
    chk("fd_addr", 32'(sram_addr), 32'h4B009);
    step();
    frame_done      = 1'b0;
    completed_frame = 1'b0;
    for (int i = 0; i < 9; i++) begin
      #1;
      chk("wait_we",    32'(sram_we), 32'd0);
      chk("wait_oe",    32'(sram_oe), 32'd0);
      chk("wait_wrrdy", 32'(wr_bus.wr_ready), 32'd0);
      chk("wait_rdy",   32'(raster_ready), 32'd0);
      chk("wait_front", 32'(front_buffer_addr), 32'(exp_front));
      step();
    end
    completed_frame = 1'b1;
    step();
    completed_frame = 1'b0;
    swap_model();
    #1;
    chk("swap1_front", 32'(front_buffer_addr), 32'h4B000);

    // Clear of the new back buffer with display reads stealing about half the cycles.
    n   = 0;
    cyc = 0;
    while (n < int'(WORDS) && cyc < 200) begin
      dre = 1'($urandom);
      ra  = 20'($urandom);
      disp_read_enable = dre;
      disp_read_addr   = ra;
      #1;
      if (dre) begin
        chk("steal_we",   32'(sram_we), 32'd0);
        chk("steal_oe",   32'(sram_oe), 32'd1);
        chk("steal_addr", 32'(sram_addr), 32'(ra));
      end else begin
        chk_clear_word(n);
        n++;
      end
      chk("steal_rdy", 32'(raster_ready), 32'd0);
      cyc++;
      step();
    end
    chk("steal_count", 32'(n), 32'(WORDS));
    disp_read_enable = 1'b0;
    #1;
    chk("steal_rdy_end", 32'(raster_ready), 32'd1);

    // frame_done and completed_frame together: no swap until the next pulse.
    frame_done      = 1'b1;
    completed_frame = 1'b1;
    step();
    frame_done      = 1'b0;
    completed_frame = 1'b0;
    step();
    step();
    #1;
    chk("noswap_front", 32'(front_buffer_addr), 32'(exp_front));
    chk("noswap_we",    32'(sram_we), 32'd0);
    completed_frame = 1'b1;
    step();
    completed_frame = 1'b0;
    swap_model();
    #1;
    chk("swap2_front", 32'(front_buffer_addr), 32'h00000);
    clear_no_reads();

    // Another frame so the clear runs on buffer 0, then reset in the middle of it.
    frame_done = 1'b1;
    step();
    frame_done      = 1'b0;
    completed_frame = 1'b1;
    step();
    completed_frame = 1'b0;
    swap_model();
    #1;
    chk("swap3_front", 32'(front_buffer_addr), 32'h4B000);
    for (int i = 0; i < 7; i++) begin
      #1;
      chk_clear_word(i);
      step();
    end
    #1;
    chk("pre_rst_addr", 32'(sram_addr), 32'h00007);
    #1;
    reset            = 1'b0;
    disp_read_enable = 1'b1;
    #1;
    chk("arst_front", 32'(front_buffer_addr), 32'h00000);
    chk("arst_we",    32'(sram_we), 32'd0);
    chk("arst_oe",    32'(sram_oe), 32'd0);
    chk("arst_addr",  32'(sram_addr), 32'h0);
    chk("arst_rdy",   32'(raster_ready), 32'd0);
    step();
    step();
    disp_read_enable = 1'b0;
    reset            = 1'b1;
    exp_front        = 20'h00000;
    exp_back         = 20'h4B000;
    clear_no_reads();
    chk("post_rst_front", 32'(front_buffer_addr), 32'h00000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
